// File: rtl/ttc_multi25.sv
// ttc_multi25: parametrised multi-channel APB timer/counter with prescaler, free-run/interval
// and one-shot modes, match compare, and sticky write-1-to-clear interrupt status.
module ttc_multi25 #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PRESC_W = 8
) (
    input  logic              pclk25,
    input  logic              p_reset25,
    input  logic              psel25,
    input  logic              penable25,
    input  logic              pwrite25,
    input  logic [7:0]        paddr25,
    input  logic [31:0]       pwdata25,
    output logic [31:0]       prdata25,
    output logic [NUM_CH-1:0] interrupt25
);
    localparam int unsigned        FLAG_W    = 2 * NUM_CH;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic                    w_wr;
    logic [3:0]              w_ch;
    logic [1:0]              w_reg;
    logic                    w_glob;
    logic [FLAG_W-1:0]       w_set;
    logic [FLAG_W-1:0]       w_clr;
    logic [NUM_CH-1:0][31:0] w_rd_ch;
    logic                    w_unused_bits;

    logic [FLAG_W-1:0]       r_int_status;
    logic [FLAG_W-1:0]       r_int_en;

    assign w_wr          = psel25 & penable25 & pwrite25;
    assign w_ch          = paddr25[7:4];
    assign w_reg         = paddr25[3:2];
    assign w_glob        = (w_ch == 4'hF);
    assign w_clr         = (w_wr && w_glob && w_reg == 2'd0) ? pwdata25[FLAG_W-1:0] : '0;
    assign w_unused_bits = ^{paddr25[1:0], pwdata25};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic               r_en;
        logic               r_mode;
        logic               r_oneshot;
        logic               r_match_en;
        logic [PRESC_W-1:0] r_presc;
        logic [PRESC_W-1:0] r_pcnt;
        logic [CNT_W-1:0]   r_load;
        logic [CNT_W-1:0]   r_match;
        logic [CNT_W-1:0]   r_count;

        logic               w_sel;
        logic               w_wr_ctrl;
        logic               w_restart;
        logic               w_tick;
        logic               w_tick_eff;
        logic               w_wrap;
        logic [CNT_W-1:0]   w_next;
        logic [31:0]        w_rd;

        assign w_sel      = w_wr & (w_ch == 4'(k));
        assign w_wr_ctrl  = w_sel & (w_reg == 2'd0);
        assign w_restart  = w_wr_ctrl & pwdata25[4];
        // >= keeps the prescaler bounded if PRESC is lowered below the running count
        assign w_tick     = r_en & (r_pcnt >= r_presc);
        assign w_tick_eff = w_tick & ~w_restart;

        always_comb begin
            w_wrap = 1'b0;
            w_next = r_count + CNT_ONE;
            if (r_mode) begin
                if (r_count >= r_load) begin
                    w_next = '0;
                    w_wrap = 1'b1;
                end
            end else begin
                w_wrap = &r_count;
            end
        end

        assign w_set[2*k]   = w_tick_eff & w_wrap;
        assign w_set[2*k+1] = w_tick_eff & r_match_en & (w_next == r_match);

        always_ff @(posedge pclk25) begin
            if (p_reset25) begin
                r_en       <= 1'b0;
                r_mode     <= 1'b0;
                r_oneshot  <= 1'b0;
                r_match_en <= 1'b0;
                r_presc    <= '0;
                r_pcnt     <= '0;
                r_load     <= '0;
                r_match    <= '0;
                r_count    <= '0;
            end else begin
                if (w_wr_ctrl) begin
                    r_en       <= pwdata25[0];
                    r_mode     <= pwdata25[1];
                    r_oneshot  <= pwdata25[2];
                    r_match_en <= pwdata25[3];
                    r_presc    <= pwdata25[8 +: PRESC_W];
                end else if (w_tick && w_wrap && r_oneshot) begin
                    r_en <= 1'b0;
                end
                if (w_sel && w_reg == 2'd1) begin
                    r_load <= pwdata25[CNT_W-1:0];
                end
                if (w_sel && w_reg == 2'd2) begin
                    r_match <= pwdata25[CNT_W-1:0];
                end
                if (w_restart) begin
                    r_count <= '0;
                    r_pcnt  <= '0;
                end else if (r_en) begin
                    r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_ONE;
                    if (w_tick) begin
                        r_count <= w_next;
                    end
                end
            end
        end

        always_comb begin
            w_rd = '0;
            case (w_reg)
                2'd0: begin
                    w_rd[0]            = r_en;
                    w_rd[1]            = r_mode;
                    w_rd[2]            = r_oneshot;
                    w_rd[3]            = r_match_en;
                    w_rd[8 +: PRESC_W] = r_presc;
                end
                2'd1:    w_rd = 32'(r_load);
                2'd2:    w_rd = 32'(r_match);
                default: w_rd = 32'(r_count);
            endcase
        end

        assign w_rd_ch[k]     = w_rd;
        assign interrupt25[k] = |(r_int_status[2*k +: 2] & r_int_en[2*k +: 2]);
    end

    // Hardware set takes priority over a same-edge W1C clear.
    always_ff @(posedge pclk25) begin
        if (p_reset25) begin
            r_int_status <= '0;
            r_int_en     <= '0;
        end else begin
            r_int_status <= (r_int_status & ~w_clr) | w_set;
            if (w_wr && w_glob && w_reg == 2'd1) begin
                r_int_en <= pwdata25[FLAG_W-1:0];
            end
        end
    end

    always_comb begin
        prdata25 = '0;
        if (psel25 && !pwrite25) begin
            if (w_glob) begin
                if (w_reg == 2'd0) begin
                    prdata25 = 32'(r_int_status);
                end else if (w_reg == 2'd1) begin
                    prdata25 = 32'(r_int_en);
                end
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_ch == 4'(k)) begin
                        prdata25 = w_rd_ch[k];
                    end
                end
            end
        end
    end

endmodule
